// File: rtl/muldiv_seq_pkg.sv
// Shared ALU definitions: HI/LO op codes, multiply/divide FSM states and op decode.
package muldiv_seq_pkg;

   localparam int OP_W = 6;

   localparam logic [OP_W-1:0] OP_MFHI  = 6'b010000;
   localparam logic [OP_W-1:0] OP_MFLO  = 6'b010010;
   localparam logic [OP_W-1:0] OP_MULT  = 6'b011000;
   localparam logic [OP_W-1:0] OP_MULTU = 6'b011001;
   localparam logic [OP_W-1:0] OP_MADD  = 6'b011100;
   localparam logic [OP_W-1:0] OP_MADDU = 6'b011101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } md_state_t;

   typedef struct packed {
      logic legal;
      logic sgn;
      logic acc;
   } md_dec_t;

   function automatic md_dec_t decode_op(input logic [OP_W-1:0] op);
      md_dec_t d;
      d = '0;
      case (op)
         OP_MULT:  d = '{legal: 1'b1, sgn: 1'b1, acc: 1'b0};
         OP_MULTU: d = '{legal: 1'b1, sgn: 1'b0, acc: 1'b0};
         OP_MADD:  d = '{legal: 1'b1, sgn: 1'b1, acc: 1'b1};
         OP_MADDU: d = '{legal: 1'b1, sgn: 1'b0, acc: 1'b1};
         default:  d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiplier / multiply-accumulate into the HI/LO pair.
// Operands are reduced to magnitudes; the sign is applied once at the end.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = OP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   md_state_t          state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod;
   logic               neg;
   logic               accum;

   md_dec_t            dec;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     step_sum;
   logic [2*WIDTH-1:0] signed_prod;
   logic [2*WIDTH-1:0] result;

   always_comb begin
      dec   = decode_op(op);
      abs_a = (dec.sgn && a[WIDTH-1]) ? -a : a;
      abs_b = (dec.sgn && b[WIDTH-1]) ? -b : b;
   end

   // Multiplier sits in the low half and shifts out as the product shifts in.
   always_comb begin
      step_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      signed_prod = neg ? -prod : prod;
      result      = signed_prod + (accum ? {hi, lo} : '0);
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         mcand <= '0;
         prod  <= '0;
         neg   <= 1'b0;
         accum <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (dec.legal) begin
                     mcand <= abs_a;
                     prod  <= {{WIDTH{1'b0}}, abs_b};
                     neg   <= dec.sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                     accum <= dec.acc;
                     cnt   <= '0;
                     state <= CALC;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            CALC: begin
               prod <= {step_sum, prod[WIDTH-1:1]};
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) state <= FINISH;
            end
            FINISH: begin
               {hi, lo} <= result;
               done     <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq against a 64-bit arithmetic model of HI:LO.
module tb_muldiv_seq;

   localparam int W = 32;
   localparam logic [5:0] MULT  = 6'b011000;
   localparam logic [5:0] MULTU = 6'b011001;
   localparam logic [5:0] MADD  = 6'b011100;
   localparam logic [5:0] MADDU = 6'b011101;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [5:0]   op = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, err;
   logic [W-1:0] hi, lo;

   int           vecs = 0;
   int           errs = 0;
   logic [63:0]  mdl = '0;

   muldiv_seq #(.WIDTH(W), .OPW(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_res(input logic [5:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input logic [63:0] prev);
      logic [63:0] r;
      if (o == MULT || o == MADD)
         r = longint'($signed(x)) * longint'($signed(y));
      else
         r = {32'b0, x} * {32'b0, y};
      if (o == MADD || o == MADDU) r = r + prev;
      return r;
   endfunction

   // Called #1 after a rising edge; returns #1 after the edge that raises done.
   task automatic run_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
      int lat, bcnt;
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; bcnt = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      mdl = ref_res(o, x, y, mdl);
      chk({tag, "_lat"}, 64'(lat), 64'(W + 1));
      chk({tag, "_busy"}, 64'(bcnt), 64'(W + 1));
      chk({tag, "_res"}, {hi, lo}, mdl);
   endtask

   initial begin
      logic [5:0] ops [4];
      int pulses, lat;
      ops = '{MULT, MULTU, MADD, MADDU};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_hilo", {hi, lo}, 64'h0);
      chk("rst_flags", {61'b0, busy, done, err}, 64'h0);
      rst = 1'b0;

      run_op(MULT, 32'hFFFFFFFD, 32'd5, "mult_neg");
      chk("mult_neg_k", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
      run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
      chk("multu_max_k", {hi, lo}, 64'hFFFFFFFE_00000001);
      run_op(MULT, 32'h80000000, 32'h80000000, "mult_min");
      chk("mult_min_k", {hi, lo}, 64'h40000000_00000000);
      run_op(MULTU, 32'd4, 32'd4, "multu_16");
      run_op(MADD, 32'd2, 32'd3, "madd_b2b");
      chk("madd_b2b_k", {hi, lo}, 64'd22);
      run_op(MULT, 32'hFFFFFFFF, 32'd1, "preset_ones");
      run_op(MADDU, 32'd1, 32'd1, "maddu_wrap");
      chk("maddu_wrap_k", {hi, lo}, 64'h0);
      run_op(MULT, 32'd123, 32'hFFFFFF85, "mult_pos");

      // Illegal op: err for exactly one cycle, HI/LO untouched.
      op = 6'b100000; a = 32'd9; b = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("ill_err", {62'b0, err, done}, 64'h2);
      chk("ill_busy", {63'b0, busy}, 64'h0);
      @(posedge clk); #1;
      chk("ill_err_drop", {63'b0, err}, 64'h0);
      chk("ill_hilo", {hi, lo}, mdl);

      // start during CALC must not disturb the operation in flight.
      op = MULT; a = 32'd7; b = 32'hFFFFFFF7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      op = MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
      mdl = ref_res(MULT, 32'd7, 32'hFFFFFFF7, mdl);
      chk("ign_done", {63'b0, done}, 64'h1);
      chk("ign_res", {hi, lo}, mdl);
      @(posedge clk); #1;
      chk("ign_no_second", {63'b0, busy}, 64'h0);

      // Reset part-way through an operation aborts it.
      op = MULT; a = 32'd1000; b = 32'd1000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mdl = '0;
      chk("abort_hilo", {hi, lo}, 64'h0);
      chk("abort_flags", {61'b0, busy, done, err}, 64'h0);
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) pulses++;
      end
      chk("abort_quiet", 64'(pulses), 64'h0);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] x, y;
         case ($urandom_range(0, 5))
            0: x = 32'h0;
            1: x = 32'h80000000;
            2: x = 32'hFFFFFFFF;
            default: x = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: y = 32'h1;
            1: y = 32'h80000000;
            2: y = 32'hFFFFFFFF;
            default: y = $urandom;
         endcase
         if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
         run_op(ops[$urandom_range(0, 3)], x, y, "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
Parameters:
REQ-001 WIDTH, 32, operand and HI/LO width; legal range 4..64.
REQ-002 OPW, 6, operation-code width; equals the ALU control code width.

Ports (name  direction  width  meaning):
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request; sampled only while idle.
REQ-006 op  in  OPW  operation code, sampled with start.
REQ-007 a  in  WIDTH  multiplicand (rs), sampled with start.
REQ-008 b  in  WIDTH  multiplier (rt), sampled with start.
REQ-009 busy  out  1  high while an operation is in flight.
REQ-010 done  out  1  one-cycle pulse; hi/lo hold the new result in that cycle.
REQ-011 err  out  1  one-cycle pulse; an unsupported op was presented with start.
REQ-012 hi  out  WIDTH  architectural HI register.
REQ-013 lo  out  WIDTH  architectural LO register.

Function
REQ-014 The block SHALL decode these ops: 6'b011000 MULT (signed), 6'b011001 MULTU, 6'b011100 MADD (signed), 6'b011101 MADDU.
REQ-015 The FSM SHALL have the states IDLE, CALC and FINISH; busy SHALL equal (state != IDLE).
REQ-016 IDLE SHALL behave as follows: start with a legal op captures |a|, |b|, the product sign and the accumulate flag, clears the step counter and moves to CALC.
REQ-017 For unsigned ops, |x| SHALL equal x; for signed ops, |x| SHALL be the two's-complement magnitude as a WIDTH-bit unsigned value, so the most-negative value is legal.
REQ-018 In IDLE, start with an illegal op SHALL pulse err in the next cycle, remain in IDLE and leave hi/lo unchanged.
REQ-019 CALC SHALL perform one radix-2 shift-add step per cycle for exactly WIDTH cycles into a 2*WIDTH-bit partial product, then move to FINISH.
REQ-020 FINISH SHALL negate the product if the sign is set and add {hi,lo} if the accumulate flag is set.
REQ-021 The FINISH addition SHALL wrap modulo 2^(2*WIDTH).
REQ-022 In FINISH, the result SHALL be written to {hi,lo}, done SHALL be registered high for the next cycle, and the state SHALL return to IDLE.
REQ-023 Latency: with start sampled at edge E0, the result SHALL be written and done raised at edge E(WIDTH+1).
REQ-024 busy SHALL be high from E0 to E(WIDTH+1); one operation takes WIDTH+1 cycles.
REQ-025 start while busy SHALL be ignored: no queuing, no err, no effect on the operation in flight.
REQ-026 start in the cycle done is high SHALL be accepted, because the state is IDLE.
REQ-027 A MADD/MADDU started back-to-back SHALL accumulate onto the just-written result.
REQ-028 hi and lo SHALL change only in FINISH or on reset.
REQ-029 done and err SHALL never be high in the same cycle.

Reset
REQ-030 rst SHALL force state=IDLE, hi=0, lo=0, busy=0, done=0, err=0, and clear the counter and partial product.
REQ-031 rst asserted mid-operation SHALL abort it without writing hi/lo and without pulsing done.
REQ-032 rst SHALL take priority over start in the same cycle.

Structure
REQ-033 The op-code constants (MULT, MULTU, MADD, MADDU, MFHI, MFLO) and the FSM state encoding SHALL live in the shared ALU package used by alu_control.
REQ-034 The block SHALL be a single module with no sub-module; the shift-add step, negation and accumulate adder SHALL be inline.

Verification (WIDTH=32)
REQ-035 MULT a=0xFFFFFFFD (-3), b=5 -> done at E33 with hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for 33 cycles.
REQ-036 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 MULT a=b=0x80000000 -> hi=0x40000000, lo=0.
REQ-038 MULTU 4*4 (hi:lo=0:16), then MADD 2*3 started in the done cycle -> hi=0, lo=22.
REQ-039 With hi:lo preset to 0xFFFFFFFF:0xFFFFFFFF, MADDU 1*1 -> hi=0, lo=0 (wrap).
REQ-040 Three directed cases SHALL be covered:
- op=6'b100000 with start -> err pulses for 1 cycle and hi/lo are unchanged.
- start pulsed at cycle 10 of a MULT -> ignored, original result is unchanged.
- rst at cycle 15 of a MULT -> hi=lo=0, no done pulse, and busy=0 the next cycle.
